alu_sequencer: RTL and testbench

Control-side counterpart of the 8-bit combinational ALU. Accepts commands over a valid/ready stream and holds two operand registers, A and B. It drives the ALU's operand and select inputs, captures the ALU result, writes it back, and returns it over a second valid/ready stream. It sits between the instruction source (test harness or future fetch unit) and the ALU instance, which is external to this block.

---
 rtl/alu_sequencer_pkg.sv | 37 +++
 rtl/alu_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: command/state encodings, ALU select
// codes and instruction field positions.
package alu_sequencer_pkg;

  localparam int WIDTH_D   = 8;
  localparam int SELW_D    = 3;
  localparam int NUM_OPS_D = 4;
  localparam int INSTR_W   = 14;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    CMD_LDA  = 2'b00,
    CMD_LDB  = 2'b01,
    CMD_EXEC = 2'b10,
    CMD_OUT  = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // instr = {cmd[13:12], sel[11:9], dst[8], imm[7:0]}
  localparam int CMD_HI  = 13;
  localparam int CMD_LO  = 12;
  localparam int SEL_HI  = 11;
  localparam int SEL_LO  = 9;
  localparam int DST_BIT = 8;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

endpackage

// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational ALU: two operand registers,
// a three-state IDLE/EXEC/RESP FSM and valid/ready command and response streams.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_D,
  parameter int SELW    = SELW_D,
  parameter int NUM_OPS = NUM_OPS_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [SELW-1:0]    alu_s,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_zero,
  output logic               res_err,
  output state_t             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Ready never depends combinationally on the partner's valid.

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SELW-1:0]  r_s;
  logic             r_dst;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_zero;
  logic             r_res_err;

  cmd_t             w_cmd;
  logic [SELW-1:0]  w_sel;
  logic             w_dst;
  logic [WIDTH-1:0] w_imm;
  logic             w_sel_ok;
  logic             w_accept;
  logic [WIDTH-1:0] w_out_val;

  assign w_cmd     = cmd_t'(instr[CMD_HI:CMD_LO]);
  assign w_sel     = SELW'(instr[SEL_HI:SEL_LO]);
  assign w_dst     = instr[DST_BIT];
  assign w_imm     = WIDTH'(instr[IMM_HI:IMM_LO]);
  assign w_sel_ok  = (int'(w_sel) < NUM_OPS);
  assign w_accept  = instr_valid && (r_state == ST_IDLE);
  assign w_out_val = w_dst ? r_b : r_a;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (instr_valid) begin
          case (w_cmd)
            CMD_EXEC: w_state_nxt = w_sel_ok ? ST_EXEC : ST_RESP;
            CMD_OUT:  w_state_nxt = ST_RESP;
            default:  w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (res_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_s        <= '0;
      r_dst      <= 1'b0;
      r_res_data <= '0;
      r_res_zero <= 1'b0;
      r_res_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        case (w_cmd)
          CMD_LDA: r_a <= w_imm;
          CMD_LDB: r_b <= w_imm;
          CMD_EXEC: begin
            if (w_sel_ok) begin
              r_s   <= w_sel;
              r_dst <= w_dst;
            end else begin
              // Illegal select: report an error, leave operands and alu_s alone.
              r_res_data <= '0;
              r_res_zero <= 1'b0;
              r_res_err  <= 1'b1;
            end
          end
          default: begin
            r_res_data <= w_out_val;
            r_res_zero <= (w_out_val == '0);
            r_res_err  <= 1'b0;
          end
        endcase
      end else if (r_state == ST_EXEC) begin
        if (r_dst) r_b <= alu_out;
        else       r_a <= alu_out;
        r_res_data <= alu_out;
        r_res_zero <= (alu_out == '0);
        r_res_err  <= 1'b0;
      end
    end
  end

  assign instr_ready = (r_state == ST_IDLE);
  assign res_valid   = (r_state == ST_RESP);
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_s       = r_s;
  assign res_data    = r_res_data;
  assign res_zero    = r_res_zero;
  assign res_err     = r_res_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: table of load/exec vectors plus hand
// sequences for back-to-back loads, backpressure and reset during EXEC.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [13:0] instr;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_s;
  logic [7:0]  alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_zero;
  logic        res_err;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_err(res_err), .dbg_state(dbg_state)
  );

  // External ALU reference
  always_comb begin
    case (alu_s)
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      default: alu_out = 8'h00;
    endcase
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk(input logic [1:0] c, input logic [2:0] s,
                                     input logic d, input logic [7:0] imm);
    return {c, s, d, imm};
  endfunction

  // Drive one command, hold it for one accepting edge, then drop valid.
  task automatic send(input logic [13:0] ins);
    @(negedge clk);
    check("instr_ready_before_send", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Called #1 after an accept edge: count cycles until res_valid (bounded).
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic complete_resp();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("instr_ready_after_resp", instr_ready, 1);
    check("res_valid_after_resp", res_valid, 0);
  endtask

  task automatic read_reg(input logic d, input logic [7:0] exp, input string name);
    int lat;
    send(mk(CMD_OUT, 3'b000, d, 8'h00));
    wait_resp(lat);
    check({name, "_lat"}, lat, 1);
    check(name, res_data, exp);
    check({name, "_zero"}, res_zero, (exp == 8'h00));
    check({name, "_err"}, res_err, 0);
    complete_resp();
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic       dst;
    logic [7:0] exp_data;
    logic       exp_zero;
    logic       exp_err;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         lat;
    logic [2:0] exp_s;

    vecs[0] = '{8'h05, 8'h03, 3'b000, 1'b0, 8'h08, 1'b0, 1'b0, 8'h08, 8'h03, 2};
    vecs[1] = '{8'h03, 8'h05, 3'b001, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h03, 8'hFE, 2};
    vecs[2] = '{8'hF0, 8'h0F, 3'b010, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h0F, 2};
    vecs[3] = '{8'hF0, 8'h0F, 3'b011, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hF0, 8'hFF, 2};
    vecs[4] = '{8'h11, 8'h22, 3'b101, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'h22, 1};
    vecs[5] = '{8'hFF, 8'h01, 3'b000, 1'b1, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 2};
    vecs[6] = '{8'h00, 8'h01, 3'b001, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'h01, 2};
    vecs[7] = '{8'h3C, 8'hA5, 3'b111, 1'b1, 8'h00, 1'b0, 1'b1, 8'h3C, 8'hA5, 1};

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    res_ready   = 1'b0;
    exp_s       = 3'b000;
    #12;
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_s", alu_s, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_zero", res_zero, 0);
    check("rst_res_err", res_err, 0);
    check("rst_instr_ready", instr_ready, 1);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven load/exec vectors
    for (int i = 0; i < 8; i++) begin
      send(mk(CMD_LDA, 3'b000, 1'b0, vecs[i].a));
      send(mk(CMD_LDB, 3'b000, 1'b0, vecs[i].b));
      check($sformatf("v%0d_load_a", i), alu_a, vecs[i].a);
      check($sformatf("v%0d_load_b", i), alu_b, vecs[i].b);
      send(mk(CMD_EXEC, vecs[i].sel, vecs[i].dst, 8'h00));
      wait_resp(lat);
      if (vecs[i].exp_err == 1'b0) exp_s = vecs[i].sel;
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_res_data", i), res_data, vecs[i].exp_data);
      check($sformatf("v%0d_res_zero", i), res_zero, vecs[i].exp_zero);
      check($sformatf("v%0d_res_err", i), res_err, vecs[i].exp_err);
      check($sformatf("v%0d_alu_s", i), alu_s, exp_s);
      check($sformatf("v%0d_reg_a", i), alu_a, vecs[i].exp_a);
      check($sformatf("v%0d_reg_b", i), alu_b, vecs[i].exp_b);
      complete_resp();
      if (i == 0) read_reg(1'b0, 8'h08, "v0_out_a");
      if (i == 1) read_reg(1'b1, 8'hFE, "v1_out_b");
    end

    // Back-to-back loads with valid held high across two edges
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mk(CMD_LDA, 3'b000, 1'b0, 8'h77);
    @(posedge clk); #1;
    check("b2b_ready", instr_ready, 1);
    instr = mk(CMD_LDB, 3'b000, 1'b0, 8'h88);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("b2b_a", alu_a, 8'h77);
    check("b2b_b", alu_b, 8'h88);

    // Backpressure: response held, LDA attempts ignored
    send(mk(CMD_LDA, 3'b000, 1'b0, 8'h01));
    send(mk(CMD_LDB, 3'b000, 1'b0, 8'h02));
    send(mk(CMD_EXEC, ALU_ADD, 1'b1, 8'h00));
    wait_resp(lat);
    check("bp_latency", lat, 2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      instr_valid = (c % 2 == 0);
      instr       = mk(CMD_LDA, 3'b000, 1'b0, 8'hAA);
      @(posedge clk); #1;
      check($sformatf("bp_valid_%0d", c), res_valid, 1);
      check($sformatf("bp_data_%0d", c), res_data, 8'h03);
      check($sformatf("bp_ready_%0d", c), instr_ready, 0);
      check($sformatf("bp_a_%0d", c), alu_a, 8'h01);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    check("bp_ready_before_release", instr_ready, 0);
    complete_resp();
    read_reg(1'b0, 8'h01, "bp_out_a");
    read_reg(1'b1, 8'h03, "bp_out_b");

    // Reset asserted while an add is in EXEC
    send(mk(CMD_LDA, 3'b000, 1'b0, 8'h10));
    send(mk(CMD_LDB, 3'b000, 1'b0, 8'h20));
    send(mk(CMD_EXEC, ALU_ADD, 1'b0, 8'h00));
    check("rm_in_exec", dbg_state, ST_EXEC);
    rst_n = 1'b0;
    #1;
    check("rm_res_valid", res_valid, 0);
    check("rm_alu_a", alu_a, 0);
    check("rm_alu_b", alu_b, 0);
    check("rm_alu_s", alu_s, 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rm_no_writeback", alu_a, 0);
    check("rm_no_resp", res_valid, 0);
    check("rm_instr_ready", instr_ready, 1);
    read_reg(1'b0, 8'h00, "rm_out_a");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
